// File: rtl/game2048_pkg.sv
// Shared types, constants and board helpers for the 2048 datapath.
// Boards are 16 cells of 4-bit codes, index = row*4 + col; code n means tile 2^n.
package game2048_pkg;

  localparam int unsigned NUM_CELLS = 16;
  localparam int unsigned GRID_DIM  = 4;
  localparam int unsigned CELL_W    = 4;
  localparam int unsigned LFSR_W    = 16;

  typedef logic [CELL_W-1:0]                 cell_t;
  typedef logic [NUM_CELLS-1:0][CELL_W-1:0]  board_t;

  localparam cell_t CELL_EMPTY = 4'd0;
  localparam cell_t TILE_2     = 4'd1;
  localparam cell_t TILE_4     = 4'd2;

  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    SP_IDLE,
    SP_SEEK,
    SP_CHECK,
    SP_DONE
  } spawn_state_e;

  // One LFSR step: shift left, parity of tapped bits enters bit 0
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

  // True when any cell has reached the winning code
  function automatic logic board_win(input board_t b, input cell_t win_code);
    logic w;
    w = 1'b0;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (b[4'(i)] >= win_code) w = 1'b1;
    end
    return w;
  endfunction

  // True when no empty cell and no orthogonal equal pair exist (no row wrap)
  function automatic logic board_lose(input board_t b);
    logic any_move;
    any_move = 1'b0;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (b[4'(i)] == CELL_EMPTY) any_move = 1'b1;
    end
    for (int unsigned r = 0; r < GRID_DIM; r++) begin
      for (int unsigned c = 0; c < GRID_DIM - 1; c++) begin
        if (b[4'(r * GRID_DIM + c)] == b[4'(r * GRID_DIM + c + 1)]) any_move = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_CELLS - GRID_DIM; i++) begin
      if (b[4'(i)] == b[4'(i + GRID_DIM)]) any_move = 1'b1;
    end
    return !any_move;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, loaded with SEED on synchronous reset.
// Ports: clk, rst (sync, active high), q (current state).
module lfsr16
  import game2048_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  always_comb begin
    q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/tile_spawner.sv
// Post-slide stage: inserts a 2 or 4 tile into a pseudo-random empty cell when
// the move changed the board, then evaluates win/lose and pulses done.
// Ports: clk, rst (sync, active high), start, board_prev, board_in in;
//        board_out, busy, done, spawned, win, lose, rand_dbg out (all registered).
module tile_spawner
  import game2048_pkg::*;
#(
  parameter int unsigned       WIN_EXP   = 11,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  board_t            board_prev,
  input  board_t            board_in,
  output board_t            board_out,
  output logic              busy,
  output logic              done,
  output logic              spawned,
  output logic              win,
  output logic              lose,
  output logic [LFSR_W-1:0] rand_dbg
);

  localparam cell_t WIN_CODE = CELL_W'(WIN_EXP);

  logic [LFSR_W-1:0] lfsr;

  spawn_state_e state_q, state_d;
  board_t       work_q, work_d;
  logic [3:0]   ptr_q, ptr_d;
  cell_t        val_q, val_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         spawn_q, spawn_d;
  board_t       board_out_q, board_out_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         spawned_q, spawned_d;
  logic         win_q, win_d;
  logic         lose_q, lose_d;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    ptr_d       = ptr_q;
    val_d       = val_q;
    cnt_d       = cnt_q;
    spawn_d     = spawn_q;
    board_out_d = board_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    spawned_d   = spawned_q;
    win_d       = win_q;
    lose_d      = lose_q;

    case (state_q)
      SP_IDLE: begin
        if (start) begin
          work_d  = board_in;
          ptr_d   = lfsr[3:0];
          val_d   = (lfsr[7:4] == 4'h0) ? TILE_4 : TILE_2;
          cnt_d   = 5'd0;
          spawn_d = 1'b0;
          busy_d  = 1'b1;
          state_d = (board_in != board_prev) ? SP_SEEK : SP_CHECK;
        end
      end
      SP_SEEK: begin
        // 16 occupied cells examined: give up rather than spin forever
        if (cnt_q == 5'd16) begin
          state_d = SP_CHECK;
        end else if (work_q[ptr_q] == CELL_EMPTY) begin
          work_d[ptr_q] = val_q;
          spawn_d       = 1'b1;
          state_d       = SP_CHECK;
        end else begin
          ptr_d = ptr_q + 4'd1;
          cnt_d = cnt_q + 5'd1;
        end
      end
      SP_CHECK: begin
        board_out_d = work_q;
        spawned_d   = spawn_q;
        win_d       = board_win(work_q, WIN_CODE);
        lose_d      = board_lose(work_q);
        busy_d      = 1'b0;
        done_d      = 1'b1;
        state_d     = SP_DONE;
      end
      SP_DONE: begin
        state_d = SP_IDLE;
      end
      default: begin
        state_d = SP_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SP_IDLE;
      work_q      <= '0;
      ptr_q       <= 4'd0;
      val_q       <= CELL_EMPTY;
      cnt_q       <= 5'd0;
      spawn_q     <= 1'b0;
      board_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      spawned_q   <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      ptr_q       <= ptr_d;
      val_q       <= val_d;
      cnt_q       <= cnt_d;
      spawn_q     <= spawn_d;
      board_out_q <= board_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      spawned_q   <= spawned_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
    end
  end

  assign board_out = board_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign spawned   = spawned_q;
  assign win       = win_q;
  assign lose      = lose_q;
  assign rand_dbg  = lfsr;

endmodule

// File: tb/tb_tile_spawner.sv
// Directed self-checking bench for tile_spawner.
module tb_tile_spawner;
  import game2048_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  board_t      board_prev;
  board_t      board_in;
  board_t      board_out;
  logic        busy;
  logic        done;
  logic        spawned;
  logic        win;
  logic        lose;
  logic [15:0] rand_dbg;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] lfsr_m;

  tile_spawner #(.WIN_EXP(11), .LFSR_SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .board_prev (board_prev),
    .board_in   (board_in),
    .board_out  (board_out),
    .busy       (busy),
    .done       (done),
    .spawned    (spawned),
    .win        (win),
    .lose       (lose),
    .rand_dbg   (rand_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference LFSR: taps 16,14,13,11, shift left, feedback into bit 0
  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic board_t mk_fill(input cell_t v);
    board_t b;
    for (int i = 0; i < 16; i++) b[4'(i)] = v;
    return b;
  endfunction

  function automatic board_t mk_checker();
    board_t b;
    for (int i = 0; i < 16; i++) b[4'(i)] = (((i / 4) + (i % 4)) % 2 == 1) ? 4'd2 : 4'd1;
    return b;
  endfunction

  // mode 0: match low nibble only; 1: also [7:4]==0; 2: [7:4]!=0 (low nibble ignored)
  task automatic wait_lfsr(input logic [3:0] lo, input int mode);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    while (!ok && n < 4000) begin
      case (mode)
        0: ok = (lfsr_m[3:0] == lo);
        1: ok = (lfsr_m[3:0] == lo) && (lfsr_m[7:4] == 4'h0);
        default: ok = (lfsr_m[7:4] != 4'h0);
      endcase
      if (!ok) begin
        tick();
        n++;
      end
    end
    if (!ok) chk("lfsr_wait_timeout", 64'd0, 64'd1);
  endtask

  // Issue one operation; optionally pulse a second start while busy
  task automatic run_op(input board_t prev, input board_t cur, input bit inject, output int lat);
    chk("rand_dbg_at_start", 64'(rand_dbg), 64'(lfsr_m));
    board_prev = prev;
    board_in   = cur;
    start      = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    chk("busy_after_start", 64'(busy), 64'd1);
    if (inject) begin
      board_in   = mk_fill(4'd5);
      board_prev = '0;
      start      = 1'b1;
      tick();
      start    = 1'b0;
      board_in = cur;
      lat      = 2;
    end
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_op(input string tag, input int lat, input int exp_lat, input board_t exp_b,
                          input logic exp_sp, input logic exp_win, input logic exp_lose);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_board"},   64'(board_out), 64'(exp_b));
    chk({tag, "_spawned"}, 64'(spawned), 64'(exp_sp));
    chk({tag, "_win"},     64'(win), 64'(exp_win));
    chk({tag, "_lose"},    64'(lose), 64'(exp_lose));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_board_hold"}, 64'(board_out), 64'(exp_b));
  endtask

  initial begin
    board_t b, exp_b;
    cell_t  v;
    int     lat;
    int     exp_lat;
    bit     seen;
    logic [3:0] d;

    rst        = 1'b1;
    start      = 1'b0;
    board_prev = '0;
    board_in   = '0;
    tick();
    tick();
    tick();
    rst = 1'b0;

    // Reset state and LFSR stepping
    chk("rst_board_out", 64'(board_out), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_done",      64'(done), 64'd0);
    chk("rst_flags",     64'({spawned, win, lose}), 64'd0);
    chk("rst_seed",      64'(rand_dbg), 64'h0000_0000_0000_ACE1);
    tick();
    chk("lfsr_step1",    64'(rand_dbg), 64'h0000_0000_0000_59C3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lfsr_track", 64'(rand_dbg), 64'(lfsr_m));
    end

    // No-change move: straight to CHECK, done at t+2
    b = mk_checker();
    b[0] = 4'd0;
    run_op(b, b, 1'b0, lat);
    check_op("nochange", lat, 2, b, 1'b0, 1'b0, 1'b0);

    // Spawn after skipping cells 6,7,8; a start while busy must be ignored
    b = mk_fill(4'd3);
    b[9] = 4'd0;
    wait_lfsr(4'd6, 0);
    v = (lfsr_m[7:4] == 4'h0) ? 4'd2 : 4'd1;
    exp_b = b;
    exp_b[9] = v;
    run_op('0, b, 1'b1, lat);
    check_op("skip3", lat, 6, exp_b, 1'b1, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= done;
    end
    chk("ignored_start_no_done", 64'(seen), 64'd0);

    // Wrap-around search 14,15,0,1,2
    b = mk_fill(4'd3);
    b[2] = 4'd0;
    wait_lfsr(4'd14, 0);
    v = (lfsr_m[7:4] == 4'h0) ? 4'd2 : 4'd1;
    exp_b = b;
    exp_b[2] = v;
    run_op('0, b, 1'b0, lat);
    check_op("wrap", lat, 7, exp_b, 1'b1, 1'b0, 1'b0);

    // Lose detection: spawning a 2 (code 1) into cell 5 of a checkerboard is a dead end
    b = mk_checker();
    b[5] = 4'd0;
    wait_lfsr(4'd0, 2);
    d = 4'd5 - lfsr_m[3:0];
    exp_lat = int'(d) + 3;
    exp_b = b;
    exp_b[5] = 4'd1;
    run_op('0, b, 1'b0, lat);
    check_op("lose_tile2", lat, exp_lat, exp_b, 1'b1, 1'b0, 1'b1);

    // Spawning a 4 (code 2) matches the neighbours: not lost
    wait_lfsr(4'd3, 1);
    exp_b = b;
    exp_b[5] = 4'd2;
    run_op('0, b, 1'b0, lat);
    check_op("lose_tile4", lat, 5, exp_b, 1'b1, 1'b0, 1'b0);

    // Win threshold: 10 does not win, 11 does
    b = mk_checker();
    b[0] = 4'd0;
    b[10] = 4'd10;
    run_op(b, b, 1'b0, lat);
    check_op("win_below", lat, 2, b, 1'b0, 1'b0, 1'b0);
    b[10] = 4'd11;
    run_op(b, b, 1'b0, lat);
    check_op("win_at", lat, 2, b, 1'b0, 1'b1, 1'b0);

    // Full board holding an 11 with no moves: win and lose together
    b = mk_checker();
    b[10] = 4'd11;
    run_op(b, b, 1'b0, lat);
    check_op("win_and_lose", lat, 2, b, 1'b0, 1'b1, 1'b1);

    // Changed but full board: search gives up after 16 cells
    b = mk_fill(4'd3);
    run_op('0, b, 1'b0, lat);
    check_op("full_changed", lat, 19, b, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of SEEK aborts with no done pulse
    board_prev = '0;
    board_in   = mk_fill(4'd3);
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_board_out", 64'(board_out), 64'd0);
    chk("abort_busy",      64'(busy), 64'd0);
    chk("abort_done",      64'(done), 64'd0);
    chk("abort_flags",     64'({spawned, win, lose}), 64'd0);
    chk("abort_seed",      64'(rand_dbg), 64'h0000_0000_0000_ACE1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      seen |= done;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_idle_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
